// File: rtl/fu_seq_pkg.sv
// rtl/fu_seq_pkg.sv - shared widths and FSM state type for the FU sequencer
package fu_seq_pkg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 6;
  localparam int STAT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/fu_seq_arb.sv
// rtl/fu_seq_arb.sv - two-way grant logic; ties go to the requester named by ptr
module fu_seq_arb
  import fu_seq_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant_id = (valid[0] & valid[1]) ? ptr : valid[1];
    grant    = 2'b00;
    if (accept) begin
      grant = grant_id ? {valid[1], 1'b0} : {1'b0, valid[0]};
    end
  end

endmodule

// File: rtl/fu_sequencer.sv
// rtl/fu_sequencer.sv - sequences two requesters onto one external functional unit
// FU_SEQ_RR_EN selects round-robin tie breaking; otherwise requester 0 always wins ties.
module fu_sequencer
  import fu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [CTRL_W-1:0] fu_ctrl,
  input  logic [DATA_W-1:0] fu_f,
  input  logic [STAT_W-1:0] fu_status,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_f,
  output logic [STAT_W-1:0] resp_status,
  output logic              busy
);

  state_t     state, state_next;
  logic [1:0] grant;
  logic       grant_id;
  logic       accept;
  logic       rr_ptr;
  logic       take;

  // Gating on rst_n keeps both readies low while reset is held.
  assign accept = (state == IDLE) && rst_n;
  assign take   = |grant;

  fu_seq_arb u_arb (
    .valid    ({req1_valid, req0_valid}),
    .ptr      (rr_ptr),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

`ifdef FU_SEQ_RR_EN
  // Holds the id that wins the next tie, i.e. the one not granted last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (take) begin
      rr_ptr <= ~grant_id;
    end
  end
`else
  assign rr_ptr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_a        <= '0;
      fu_b        <= '0;
      fu_ctrl     <= '0;
      resp_id     <= 1'b0;
      resp_f      <= '0;
      resp_status <= '0;
    end else begin
      if (take) begin
        fu_a    <= grant_id ? req1_a    : req0_a;
        fu_b    <= grant_id ? req1_b    : req0_b;
        fu_ctrl <= grant_id ? req1_ctrl : req0_ctrl;
        resp_id <= grant_id;
      end
      if (state == EXEC) begin
        resp_f      <= fu_f;
        resp_status <= fu_status;
      end
    end
  end

endmodule

// File: tb/tb_fu_sequencer.sv
// tb/tb_fu_sequencer.sv - directed self-checking bench for fu_sequencer with a small FU model
module tb_fu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_ctrl, req1_ctrl;
  logic [31:0] fu_a, fu_b, fu_f, resp_f;
  logic [5:0]  fu_ctrl, fu_status, resp_status, stat_drive;
  logic        resp_valid, resp_ready, resp_id, busy;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Reference FU: bit5 shifts left, op 0 adds, op 1 subtracts, others AND; Z from the result.
  always_comb begin
    if (fu_ctrl[5])             fu_f = fu_a << fu_b[4:0];
    else if (fu_ctrl[4:0] == 0) fu_f = fu_a + fu_b;
    else if (fu_ctrl[4:0] == 1) fu_f = fu_a - fu_b;
    else                        fu_f = fu_a & fu_b;
    fu_status = {stat_drive[5:3], (fu_f == 32'd0), stat_drive[1:0]};
  end

  fu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .fu_a(fu_a), .fu_b(fu_b), .fu_ctrl(fu_ctrl), .fu_f(fu_f), .fu_status(fu_status),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_f(resp_f), .resp_status(resp_status), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic e;
    rst_n = 1'b0; resp_ready = 1'b0; stat_drive = 6'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd0; req0_b = 32'd0; req0_ctrl = 6'd0;
    req1_a = 32'd0; req1_b = 32'd0; req1_ctrl = 6'd0;

    // Reset state, with both valids high
    @(negedge clk); #1;
    chk("rst_ready0", req0_ready, 0); chk("rst_ready1", req1_ready, 0);
    chk("rst_busy", busy, 0); chk("rst_resp_valid", resp_valid, 0);
    chk("rst_fu_a", fu_a, 0); chk("rst_fu_ctrl", fu_ctrl, 0);
    chk("rst_resp_f", resp_f, 0); chk("rst_resp_status", resp_status, 0);
    chk("rst_resp_id", resp_id, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Single op: 5 + 3
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 6'd0; #1;
    chk("single_ready0", req0_ready, 1); chk("single_ready1", req1_ready, 0);
    chk("single_idle_busy", busy, 0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("single_exec_busy", busy, 1); chk("single_fu_a", fu_a, 5); chk("single_fu_b", fu_b, 3);
    chk("single_fu_ctrl", fu_ctrl, 0); chk("single_exec_rv", resp_valid, 0);
    @(negedge clk); #1;
    chk("single_rv", resp_valid, 1); chk("single_f", resp_f, 8);
    chk("single_id", resp_id, 0); chk("single_z", resp_status[2], 0);
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0; #1;
    chk("single_back_idle", busy, 0); chk("single_rv_drop", resp_valid, 0);
    chk("single_fu_a_hold", fu_a, 5);

    // Backpressure on a 7-2 op while requester 1 waits
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd2; req0_ctrl = 6'd1; #1;
    chk("bp_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_ctrl = 6'd0; #1;
    chk("bp_exec_ready1", req1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_rv", resp_valid, 1); chk("bp_f", resp_f, 5);
      chk("bp_id", resp_id, 0); chk("bp_ready1", req1_ready, 0);
    end
    @(negedge clk); resp_ready = 1'b1; #1;
    chk("bp_rv_last", resp_valid, 1); chk("bp_ready1_last", req1_ready, 0);
    @(negedge clk); resp_ready = 1'b0; #1;
    chk("bp_idle", busy, 0); chk("bp_grant1", req1_ready, 1); chk("bp_no_ready0", req0_ready, 0);
    @(negedge clk); req1_valid = 1'b0; #1;
    chk("r1_fu_a", fu_a, 9); chk("r1_fu_ctrl", fu_ctrl, 0);
    @(negedge clk); #1;
    chk("r1_f", resp_f, 18); chk("r1_id", resp_id, 1);
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;

    // Flag path: 0x80000000 - 1
    req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'd1; req0_ctrl = 6'd1;
    stat_drive = 6'b010010; #1;
    chk("flag_ready0", req0_ready, 1);
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("flag_status", resp_status, 6'b010010); chk("flag_f", resp_f, 32'h7fff_ffff);
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0; stat_drive = 6'd0;

    // Reset during EXEC discards the op
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 6'd0;
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("mid_exec_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("mid_busy", busy, 0); chk("mid_rv", resp_valid, 0); chk("mid_fu_a", fu_a, 0);
    chk("mid_fu_b", fu_b, 0); chk("mid_resp_f", resp_f, 0);
    chk("mid_resp_status", resp_status, 0); chk("mid_resp_id", resp_id, 0);
    @(negedge clk); #1;
    chk("mid_rv_held", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 6'd0; #1;
    chk("post_rst_ready1", req1_ready, 1); chk("post_rst_ready0", req0_ready, 0);
    @(negedge clk); req1_valid = 1'b0; #1;
    chk("post_rst_rv_exec", resp_valid, 0);
    @(negedge clk); #1;
    chk("post_rst_rv", resp_valid, 1); chk("post_rst_id", resp_id, 1); chk("post_rst_f", resp_f, 7);
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;

    // Tie arbitration straight after reset
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 6'd0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd4; req1_ctrl = 6'h20;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef FU_SEQ_RR_EN
      e = k[0];
`else
      e = 1'b0;
`endif
      #1;
      chk("tie_ready0", req0_ready, !e); chk("tie_ready1", req1_ready, e);
      @(negedge clk); #1;
      chk("tie_exec_ready0", req0_ready, 0); chk("tie_exec_ready1", req1_ready, 0);
      @(negedge clk); #1;
      chk("tie_resp_ready0", req0_ready, 0); chk("tie_resp_ready1", req1_ready, 0);
      chk("tie_id", resp_id, e); chk("tie_f", resp_f, e ? 32'd16 : 32'd2);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
